// File: rtl/pe_array_seq_if.sv
// Bundles the job, operand-handshake and PE-array control signals of pe_array_seq.
// master = attention controller / buffer side; slave = the sequencer.
interface pe_array_seq_if #(
  parameter int NUM_PES   = 32,
  parameter int LEN_WIDTH = 10,
  parameter int CNT_WIDTH = 6
);
  logic                 i_start;
  logic [LEN_WIDTH-1:0] i_num_beats;
  logic [CNT_WIDTH-1:0] i_num_pes;
  logic                 i_abort;
  logic                 i_data_valid;
  logic                 o_data_ready;
  logic                 i_exp_valid;
  logic [NUM_PES-1:0]   o_pe_en;
  logic                 o_mult_en;
  logic                 o_mult_clear;
  logic                 o_accu_en;
  logic                 o_part_last;
  logic                 o_busy;
  logic                 o_done;
  logic [LEN_WIDTH-1:0] o_beat_cnt;
  logic                 o_timeout;

  modport master (
    output i_start, i_num_beats, i_num_pes, i_abort, i_data_valid, i_exp_valid,
    input  o_data_ready, o_pe_en, o_mult_en, o_mult_clear, o_accu_en,
           o_part_last, o_busy, o_done, o_beat_cnt, o_timeout
  );

  modport slave (
    input  i_start, i_num_beats, i_num_pes, i_abort, i_data_valid, i_exp_valid,
    output o_data_ready, o_pe_en, o_mult_en, o_mult_clear, o_accu_en,
           o_part_last, o_busy, o_done, o_beat_cnt, o_timeout
  );
endinterface

// File: rtl/pe_array_seq.sv
// PE-array job sequencer: CLEAR, operand beats in RUN, DRAIN until exp-valid, DONE pulse.
// Optional DRAIN watchdog enabled by defining PE_ARRAY_SEQ_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | waiting for i_start
// CLEAR   | one-cycle multiplier/accumulator clear
// RUN     | accepting operand beats, driving array controls
// DRAIN   | waiting for the array's exp-valid
// DONE    | one-cycle o_done pulse
module pe_array_seq #(
  parameter int NUM_PES        = 32,
  parameter int LEN_WIDTH      = 10,
  parameter int CNT_WIDTH      = 6,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic           clk,
  input  logic           rst,
  pe_array_seq_if.slave  bus
);

  if (TIMEOUT_CYCLES < 1 || (2 ** CNT_WIDTH) <= NUM_PES) begin : g_param_err
    $error("pe_array_seq: invalid TIMEOUT_CYCLES or CNT_WIDTH too narrow for NUM_PES");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_RUN, S_DRAIN, S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [LEN_WIDTH-1:0] nb_q, nb_d;
  logic [CNT_WIDTH-1:0] np_q, np_d;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
  logic                 abrt_clr_q, abrt_clr_d;
  logic [NUM_PES-1:0]   pe_mask;
  logic [CNT_WIDTH-1:0] np_clamped;

`ifdef PE_ARRAY_SEQ_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] dcnt_q, dcnt_d;
  logic          to_q, to_d;
`endif

  assign np_clamped = (bus.i_num_pes > CNT_WIDTH'(NUM_PES)) ? CNT_WIDTH'(NUM_PES)
                                                           : bus.i_num_pes;

  always_comb begin
    pe_mask = '0;
    for (int i = 0; i < NUM_PES; i++) begin
      if (i < int'(np_q)) pe_mask[i] = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    nb_d       = nb_q;
    np_d       = np_q;
    cnt_d      = cnt_q;
    abrt_clr_d = 1'b0;
`ifdef PE_ARRAY_SEQ_TIMEOUT_EN
    dcnt_d     = dcnt_q;
    to_d       = to_q;
`endif
    bus.o_data_ready = 1'b0;
    bus.o_pe_en      = '0;
    bus.o_mult_en    = 1'b0;
    // The cycle after an abort still clears the array, even though we are back in IDLE.
    bus.o_mult_clear = abrt_clr_q;
    bus.o_accu_en    = 1'b0;
    bus.o_part_last  = 1'b0;
    bus.o_busy       = 1'b0;
    bus.o_done       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.i_start) begin
`ifdef PE_ARRAY_SEQ_TIMEOUT_EN
          to_d = 1'b0;
`endif
          if (bus.i_num_beats != '0) begin
            nb_d    = bus.i_num_beats;
            np_d    = np_clamped;
            cnt_d   = '0;
            state_d = S_CLEAR;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_CLEAR: begin
        bus.o_busy       = 1'b1;
        bus.o_mult_clear = 1'b1;
        if (bus.i_abort) begin
          abrt_clr_d = 1'b1;
          state_d    = S_IDLE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        bus.o_busy = 1'b1;
        if (bus.i_abort) begin
          abrt_clr_d = 1'b1;
          state_d    = S_IDLE;
        end else begin
          bus.o_data_ready = 1'b1;
          if (bus.i_data_valid) begin
            bus.o_mult_en = 1'b1;
            bus.o_accu_en = 1'b1;
            bus.o_pe_en   = pe_mask;
            cnt_d         = cnt_q + LEN_WIDTH'(1);
            if (cnt_q == nb_q - LEN_WIDTH'(1)) begin
              bus.o_part_last = 1'b1;
              state_d         = S_DRAIN;
`ifdef PE_ARRAY_SEQ_TIMEOUT_EN
              dcnt_d          = '0;
`endif
            end
          end
        end
      end
      S_DRAIN: begin
        bus.o_busy = 1'b1;
        if (bus.i_abort) begin
          abrt_clr_d = 1'b1;
          state_d    = S_IDLE;
        end else if (bus.i_exp_valid) begin
          state_d = S_DONE;
        end
`ifdef PE_ARRAY_SEQ_TIMEOUT_EN
        else if (dcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          to_d    = 1'b1;
          state_d = S_DONE;
        end else begin
          dcnt_d = dcnt_q + TW'(1);
        end
`endif
      end
      S_DONE: begin
        bus.o_done = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      nb_q       <= '0;
      np_q       <= '0;
      cnt_q      <= '0;
      abrt_clr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      nb_q       <= nb_d;
      np_q       <= np_d;
      cnt_q      <= cnt_d;
      abrt_clr_q <= abrt_clr_d;
    end
  end

`ifdef PE_ARRAY_SEQ_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dcnt_q <= '0;
      to_q   <= 1'b0;
    end else begin
      dcnt_q <= dcnt_d;
      to_q   <= to_d;
    end
  end

  assign bus.o_timeout = to_q;
`else
  assign bus.o_timeout = 1'b0;
`endif

  assign bus.o_beat_cnt = cnt_q;

endmodule

// File: doc/pe_array_seq.md
Name: pe_array_seq

Overview:
- Sequencer for the PE array: runs one dot-product/accumulate job across a programmable number of operand beats.
- Generates the array controls: per-PE enable, mult enable/clear, accumulate enable, part-last.
- Handshakes operand beats with the upstream Q/KV buffer, then waits for the array's exp-valid before reporting done.
- Sits between the top-level attention controller and the PE array.

Parameters:
- NUM_PES, 32, number of PEs driven (width of o_pe_en).
- LEN_WIDTH, 10, width of the beat-count field.
- CNT_WIDTH, 6, width of i_num_pes; must satisfy 2^CNT_WIDTH > NUM_PES.
- TIMEOUT_CYCLES, 64, DRAIN watchdog limit (used only with the optional feature).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- i_start  in  1  job start pulse; sampled only in IDLE.
- i_num_beats  in  LEN_WIDTH  beats in the job; latched on accepted start.
- i_num_pes  in  CNT_WIDTH  active PE count; latched on start; values above NUM_PES are clamped to NUM_PES.
- i_abort  in  1  cancel the current job.
- i_data_valid  in  1  upstream operand beat is valid.
- o_data_ready  out  1  sequencer accepts a beat.
- i_exp_valid  in  1  array result valid (from the PE array's o_exp_valid).
- o_pe_en  out  NUM_PES  per-PE enable.
- o_mult_en  out  1  multiplier enable.
- o_mult_clear  out  1  clear multipliers/accumulators.
- o_accu_en  out  1  accumulate enable.
- o_part_last  out  1  marks the final beat of the job.
- o_busy  out  1  job in progress.
- o_done  out  1  one-cycle job-complete pulse.
- o_beat_cnt  out  LEN_WIDTH  beats consumed in the current job.
- o_timeout  out  1  sticky watchdog flag.

Behaviour:
- Reset (async, active-high): state=IDLE; o_beat_cnt=0; o_timeout=0; latched registers=0. All outputs 0.
- States: IDLE, CLEAR, RUN, DRAIN, DONE. State, counters and latches are registered.
- Handshake controls (o_pe_en, o_mult_en, o_accu_en, o_part_last) are combinational from state and i_data_valid, so they align with the operand beat presented that cycle.
- IDLE:
  - o_busy=0; o_data_ready=0.
  - i_start with i_num_beats!=0: latch beats and clamped PE count, clear o_beat_cnt, go to CLEAR.
  - i_start with i_num_beats==0: go to DONE directly; no array activity.
- CLEAR: o_mult_clear=1 for exactly one cycle; o_pe_en=0; go to RUN.
- RUN:
  - o_data_ready=1.
  - Beat fires when i_data_valid=1. On a fire:
    - o_mult_en=1 and o_accu_en=1.
    - o_pe_en has bits [num_pes-1:0] set and all higher bits 0.
    - o_beat_cnt increments.
  - When i_data_valid=0 (stall): o_mult_en=0, o_accu_en=0, o_pe_en=0; counter holds.
  - On the beat where o_beat_cnt==num_beats-1: o_part_last=1 and go to DRAIN.
  - num_beats==1 gives CLEAR then a single beat carrying o_part_last.
- DRAIN:
  - o_data_ready=0; all array controls 0.
  - Wait for i_exp_valid=1, then go to DONE.
  - i_exp_valid seen in any other state is ignored.
- DONE: o_done=1 for one cycle; o_busy=0; go to IDLE.
- o_busy=1 in CLEAR, RUN and DRAIN.
- i_start outside IDLE is ignored.
- i_abort:
  - In CLEAR, RUN or DRAIN: takes priority over every other event that cycle. Next cycle o_mult_clear=1 (one cycle) and state=IDLE. No o_done pulse; o_beat_cnt holds its last value.
  - In IDLE or DONE: ignored.
- o_beat_cnt wraps only if num_beats = 2^LEN_WIDTH, which is not representable, so no wrap occurs.

Optional Feature:
- Macro: PE_ARRAY_SEQ_TIMEOUT_EN.
- Defined:
  - A DRAIN-cycle counter starts at 0 on DRAIN entry.
  - If it reaches TIMEOUT_CYCLES without i_exp_valid: set o_timeout (sticky) and go to DONE (o_done still pulses).
  - If i_exp_valid and the timeout occur in the same cycle, i_exp_valid wins and o_timeout stays 0.
  - o_timeout clears only on rst or on the next accepted i_start.
- Undefined: DRAIN waits indefinitely; o_timeout is tied 0; no counter is built.

Test Plan:
- Basic run:
  - Stimulus: start, beats=4, pes=8, valid held 1; exp_valid 3 cycles after part_last.
  - Response: 1 clear cycle; 4 mult_en cycles with o_pe_en=0x000000FF; part_last on the 4th beat; done 1 cycle after exp_valid; o_beat_cnt=4.
- Stalls and clamping:
  - Stimulus: beats=3, pes=40, valid pattern 1,0,0,1,1.
  - Response: mult_en only on valid cycles; o_pe_en=0xFFFFFFFF; part_last on the 5th RUN cycle.
- Zero beats:
  - Stimulus: start with beats=0.
  - Response: o_done next cycle; mult_clear, mult_en and busy never asserted.
- Abort:
  - Stimulus: abort after the 2nd of 5 beats.
  - Response: one mult_clear cycle, then IDLE; no o_done; o_beat_cnt=2; a following start runs normally.
- Timeout (macro defined):
  - Stimulus: exp_valid never asserted.
  - Response: o_timeout=1 and o_done exactly TIMEOUT_CYCLES=64 cycles after DRAIN entry.
  - Also: exp_valid asserted on cycle 64 gives o_timeout=0.
- Reset mid-job:
  - Stimulus: rst asserted during RUN.
  - Response: all outputs 0 immediately (asynchronous), state IDLE.
